// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its write-port sequencer/arbiter.
package regfile_pkg;

    localparam int unsigned RF_DATA_WIDTH = 8;
    localparam int unsigned RF_DEPTH      = 3;
    localparam int unsigned RF_NREQ       = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } wr_state_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr.sv
// Round-robin arbiter: first set request at or after ptr, wrapping; one-hot grant.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            grant_valid
);

    logic [NREQ-1:0] rot_req;
    logic [NREQ-1:0] rot_gnt;

    // Rotate so the pointer position sits at bit 0, pick the lowest set bit, rotate back.
    assign rot_req     = NREQ'({req, req} >> ptr);
    assign rot_gnt     = rot_req & (~rot_req + NREQ'(1));
    assign grant       = NREQ'({rot_gnt, rot_gnt} >> (NREQ - 32'(ptr)));
    assign grant_valid = |req;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register file write-port sequencer: zero-fills the file, then round-robin arbitrates writers.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned DEPTH      = RF_DEPTH,
    parameter int unsigned NREQ       = RF_NREQ
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_clr,
    input  logic [NREQ-1:0]            in_req_valid,
    input  logic [NREQ*DEPTH-1:0]      in_req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] in_req_data,
    output logic [NREQ-1:0]            out_req_ready,
    output logic                       out_we,
    output logic [DEPTH-1:0]           out_wr_addr,
    output logic [DATA_WIDTH-1:0]      out_wr_data,
    output logic                       out_init_done
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [DEPTH-1:0] LAST_ADDR = '1;

    wr_state_e             state;
    wr_state_e             state_nxt;
    logic [DEPTH-1:0]      cnt;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         ptr_nxt;
    logic [PW-1:0]         grant_idx;
    logic [NREQ-1:0]       grant;
    logic                  grant_valid;
    logic                  accept;
    logic [DEPTH-1:0]      sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req         (in_req_valid),
        .ptr         (ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Arbitration is live only once init_done is visible; a clear wins over any grant.
    assign accept        = (state == RUN) && out_init_done && !in_clr && grant_valid;
    assign out_req_ready = accept ? grant : '0;

    // Decode the one-hot grant into an index and the selected payload.
    always_comb begin
        grant_idx = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[PW'(i)]) begin
                grant_idx = PW'(i);
                sel_addr  = DEPTH'(in_req_addr >> (i * DEPTH));
                sel_data  = DATA_WIDTH'(in_req_data >> (i * DATA_WIDTH));
            end
        end
    end

    assign ptr_nxt = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT) begin
            if (cnt == LAST_ADDR) begin
                state_nxt = RUN;
            end
        end else if (in_clr) begin
            state_nxt = INIT;
        end
    end

    // Init walk counter, RR pointer and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            ptr           <= '0;
            out_we        <= 1'b0;
            out_wr_addr   <= '0;
            out_wr_data   <= '0;
            out_init_done <= 1'b0;
        end else begin
            out_init_done <= (state == RUN) && !in_clr;
            if (state == INIT) begin
                out_we      <= 1'b1;
                out_wr_addr <= cnt;
                out_wr_data <= '0;
                cnt         <= (cnt == LAST_ADDR) ? '0 : cnt + DEPTH'(1);
            end else begin
                cnt <= '0;
                if (accept) begin
                    // Address 0 is hardwired to zero: accept the request but drop the write.
                    out_we      <= (sel_addr != '0);
                    out_wr_addr <= sel_addr;
                    out_wr_data <= sel_data;
                    ptr         <= ptr_nxt;
                end else begin
                    out_we <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a behavioural register file on the write port.
module tb_regfile_wr_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned NR = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_clr = 1'b0;
    logic [NR-1:0]    in_req_valid = '0;
    logic [NR*AW-1:0] in_req_addr = '0;
    logic [NR*DW-1:0] in_req_data = '0;
    logic [NR-1:0]    out_req_ready;
    logic             out_we;
    logic [AW-1:0]    out_wr_addr;
    logic [DW-1:0]    out_wr_data;
    logic             out_init_done;

    logic [DW-1:0] mem [8];
    int pass_cnt  = 0;
    int total_cnt = 0;

    regfile_wr_arbiter #(
        .DATA_WIDTH (DW),
        .DEPTH      (AW),
        .NREQ       (NR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_clr        (in_clr),
        .in_req_valid  (in_req_valid),
        .in_req_addr   (in_req_addr),
        .in_req_data   (in_req_data),
        .out_req_ready (out_req_ready),
        .out_we        (out_we),
        .out_wr_addr   (out_wr_addr),
        .out_wr_data   (out_wr_data),
        .out_init_done (out_init_done)
    );

    always #5 clk = ~clk;

    // Register file model; entry 0 is hardwired to zero.
    always @(posedge clk) begin
        if (out_we && out_wr_addr != 3'd0) mem[out_wr_addr] <= out_wr_data;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_req_valid[i]          = 1'b1;
        in_req_addr[i*AW +: AW]  = a;
        in_req_data[i*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Eight zero-writes at 0..7 with ready low, then init_done on the following cycle.
    task automatic run_init(input string tag);
        for (int k = 0; k < 8; k++) begin
            tick();
            total_cnt++;
            if ({out_we, out_wr_addr, out_wr_data, out_req_ready, out_init_done} !==
                {1'b1, 3'(k), 8'h00, 4'b0000, 1'b0})
                $display("FAIL %s_walk%0d: got we=%b addr=%0d data=%h ready=%b done=%b, expected we=1 addr=%0d data=00 ready=0000 done=0",
                         tag, k, out_we, out_wr_addr, out_wr_data, out_req_ready, out_init_done, k);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({out_init_done, out_we} !== 2'b10)
            $display("FAIL %s_done: got done=%b we=%b, expected done=1 we=0", tag, out_init_done, out_we);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({out_we, out_wr_addr, out_wr_data, out_init_done, out_req_ready} !== 17'd0)
            $display("FAIL reset_values: got we=%b addr=%0d data=%h done=%b ready=%b, expected all zero",
                     out_we, out_wr_addr, out_wr_data, out_init_done, out_req_ready);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_init();
        run_init("init");
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (mem[i] !== 8'h00) $display("FAIL init_readback%0d: got %h expected 00", i, mem[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_single_write();
        set_req(1, 3'd5, 8'hA7);
        #1;
        total_cnt++;
        if (out_req_ready !== 4'b0010) $display("FAIL single_ready: got %b expected 0010", out_req_ready);
        else pass_cnt++;
        tick();
        in_req_valid = '0;
        total_cnt++;
        if ({out_we, out_wr_addr, out_wr_data} !== {1'b1, 3'd5, 8'hA7})
            $display("FAIL single_write: got we=%b addr=%0d data=%h expected we=1 addr=5 data=a7",
                     out_we, out_wr_addr, out_wr_data);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({out_we, mem[5]} !== {1'b0, 8'hA7})
            $display("FAIL single_file: got we=%b file5=%h expected we=0 file5=a7", out_we, mem[5]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        logic [3:0] one_hot;
        do_reset();
        run_init("b2b_init");
        for (int i = 0; i < 4; i++) set_req(i, 3'(i + 1), 8'h10 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            #1;
            one_hot = 4'b0001 << exp_g[k];
            total_cnt++;
            if (out_req_ready !== one_hot)
                $display("FAIL b2b_ready%0d: got %b expected %b", k, out_req_ready, one_hot);
            else pass_cnt++;
            if (k > 0) begin
                total_cnt++;
                if ({out_we, out_wr_addr, out_wr_data} !==
                    {1'b1, 3'(exp_g[k-1] + 1), 8'h10 + 8'(exp_g[k-1])})
                    $display("FAIL b2b_write%0d: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                             k - 1, out_we, out_wr_addr, out_wr_data, exp_g[k-1] + 1, 8'h10 + 8'(exp_g[k-1]));
                else pass_cnt++;
            end
            tick();
        end
        in_req_valid = '0;
        total_cnt++;
        if ({out_we, out_wr_addr, out_wr_data} !== {1'b1, 3'd1, 8'h10})
            $display("FAIL b2b_write4: got we=%b addr=%0d data=%h expected we=1 addr=1 data=10",
                     out_we, out_wr_addr, out_wr_data);
        else pass_cnt++;
    endtask

    task automatic test_addr_zero();
        set_req(2, 3'd0, 8'hFF);
        #1;
        total_cnt++;
        if (out_req_ready !== 4'b0100) $display("FAIL zero_ready: got %b expected 0100", out_req_ready);
        else pass_cnt++;
        tick();
        in_req_valid = '0;
        total_cnt++;
        if (out_we !== 1'b0) $display("FAIL zero_we: got %b expected 0", out_we);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (mem[0] !== 8'h00) $display("FAIL zero_file: got %h expected 00", mem[0]);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        set_req(0, 3'd3, 8'h5C);
        #1;
        total_cnt++;
        if (out_req_ready !== 4'b0001) $display("FAIL clr_pre_ready: got %b expected 0001", out_req_ready);
        else pass_cnt++;
        tick();
        in_req_valid = '0;
        tick();
        total_cnt++;
        if (mem[3] !== 8'h5C) $display("FAIL clr_pre_file: got %h expected 5c", mem[3]);
        else pass_cnt++;
        set_req(0, 3'd6, 8'h3D);
        in_clr = 1'b1;
        #1;
        total_cnt++;
        if (out_req_ready !== 4'b0000) $display("FAIL clr_ready: got %b expected 0000", out_req_ready);
        else pass_cnt++;
        tick();
        in_clr = 1'b0;
        total_cnt++;
        if ({out_init_done, out_req_ready} !== 5'b0_0000)
            $display("FAIL clr_enter: got done=%b ready=%b expected done=0 ready=0000", out_init_done, out_req_ready);
        else pass_cnt++;
        run_init("clr_init");
        total_cnt++;
        if ({mem[3], out_req_ready} !== {8'h00, 4'b0001})
            $display("FAIL clr_post: got file3=%h ready=%b expected file3=00 ready=0001", mem[3], out_req_ready);
        else pass_cnt++;
        tick();
        in_req_valid = '0;
        total_cnt++;
        if ({out_we, out_wr_addr, out_wr_data} !== {1'b1, 3'd6, 8'h3D})
            $display("FAIL clr_grant_write: got we=%b addr=%0d data=%h expected we=1 addr=6 data=3d",
                     out_we, out_wr_addr, out_wr_data);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_init();
        do_reset();
        tick();
        tick();
        @(posedge clk);
        #1;
        total_cnt++;
        if ({out_we, out_wr_addr} !== {1'b1, 3'd2})
            $display("FAIL rst_mid_pre: got we=%b addr=%0d expected we=1 addr=2", out_we, out_wr_addr);
        else pass_cnt++;
        #1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({out_we, out_wr_addr, out_wr_data, out_init_done} !== 13'd0)
            $display("FAIL rst_mid_async: got we=%b addr=%0d data=%h done=%b expected all zero",
                     out_we, out_wr_addr, out_wr_data, out_init_done);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        run_init("rst_mid_init");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = (i == 0) ? 8'h00 : 8'hEE;
        test_reset();
        test_init();
        test_single_write();
        test_back_to_back();
        test_addr_zero();
        test_clear();
        test_reset_mid_init();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
